prog_counter: RTL and testbench

- Parametrised, programmable free-running/one-shot counter; the next-generation replacement for the fixed 8-bit enable counter.
- Adds width parameter, up/down direction, programmable modulo limit, parallel load, one-shot mode, terminal-count pulse and run/halt state.
- Sits beside control logic as a timer/event counter in the mixed-signal test designs.

---
 rtl/prog_counter_pkg.sv | 13 +
 rtl/prog_counter_prescaler.sv | 28 ++
 rtl/prog_counter.sv | 93 +++++++++
 tb/tb_prog_counter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the programmable counter slice.
package prog_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Step-strobe generator: one strobe per (prescale+1) enabled RUN cycles.
module prog_counter_prescaler #(
   parameter int unsigned PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  restart,
   input  logic                  active,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  step
);

   logic [PRESCALE_W-1:0] cnt;

   assign step = active && (cnt >= prescale);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (active) begin
         if (cnt >= prescale) cnt <= '0;
         else                 cnt <= cnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down modulo counter with load, one-shot and terminal-count pulse.
// Optional prescaler enabled by defining PROG_COUNTER_PRESCALE_EN.
module prog_counter
   import prog_counter_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef PROG_COUNTER_PRESCALE_EN
   ,parameter int unsigned     PRESCALE_W = 4
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             start,
   input  logic             enable,
   input  logic             dir,
   input  logic [WIDTH-1:0] limit,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef PROG_COUNTER_PRESCALE_EN
   input  logic [PRESCALE_W-1:0] prescale,
`endif
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             running
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state, state_n;
   logic [WIDTH-1:0] out_n, start_val, clamped;
   logic             tc_n, at_term, step;

`ifdef PROG_COUNTER_PRESCALE_EN
   prog_counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .restart  (clear | load | start),
      .active   ((state == RUN) && enable),
      .prescale (prescale),
      .step     (step)
   );
`else
   assign step = enable;
`endif

   assign running = (state == RUN);

   always_comb begin
      state_n   = state;
      out_n     = out;
      tc_n      = 1'b0;
      start_val = (dir == DIR_UP) ? '0 : limit;
      // Up-count treats out>=limit as terminal so a lowered limit still wraps.
      at_term   = (dir == DIR_UP) ? (out >= limit) : (out == '0);
      clamped   = (load_val > limit) ? limit : load_val;

      if (clear) begin
         state_n = IDLE;
         out_n   = RESET_VAL;
      end else if (load) begin
         out_n = clamped;
      end else if (start) begin
         state_n = RUN;
         out_n   = start_val;
      end else if ((state == RUN) && step) begin
         if (at_term) begin
            tc_n = 1'b1;
            if (oneshot) state_n = HALT;
            else         out_n   = start_val;
         end else if (dir == DIR_UP) begin
            out_n = out + ONE;
         end else begin
            out_n = out - ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         out   <= RESET_VAL;
         tc    <= 1'b0;
      end else begin
         state <= state_n;
         out   <= out_n;
         tc    <= tc_n;
      end
   end

endmodule

// File: tb/tb_prog_counter.sv
// Vector-table testbench for prog_counter (WIDTH=8, RESET_VAL=0) with an expected-value queue.
module tb_prog_counter;

   typedef struct {
      logic       clr, ld;
      logic [7:0] ldv;
      logic       st, en, dr;
      logic [7:0] lim;
      logic       os;
      logic [3:0] ps;
      logic [7:0] eo;
      logic       etc, er;
   } vec_t;

   typedef struct {
      logic [7:0] eo;
      logic       etc, er;
      int         idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, clear, start, enable, dir, oneshot, load;
   logic [7:0] limit, load_val, out;
   logic       tc, running;
   logic [3:0] prescale;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   vec_t vecs[$];
   exp_t exp_q[$];

   always #5 clk = ~clk;

   prog_counter #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .start    (start),
      .enable   (enable),
      .dir      (dir),
      .limit    (limit),
      .oneshot  (oneshot),
      .load     (load),
      .load_val (load_val),
`ifdef PROG_COUNTER_PRESCALE_EN
      .prescale (prescale),
`endif
      .out      (out),
      .tc       (tc),
      .running  (running)
   );

   function automatic vec_t mk(logic clr, logic ld, logic [7:0] ldv, logic st, logic en,
                               logic dr, logic [7:0] lim, logic os, logic [7:0] eo,
                               logic etc, logic er);
      vec_t v;
      v.clr = clr; v.ld = ld; v.ldv = ldv; v.st = st; v.en = en; v.dr = dr;
      v.lim = lim; v.os = os; v.ps = 4'd0; v.eo = eo; v.etc = etc; v.er = er;
      return v;
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic check_outputs(string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("%s[%0d].out", tag, e.idx), out, e.eo);
         check($sformatf("%s[%0d].tc", tag, e.idx), {7'd0, tc}, {7'd0, e.etc});
         check($sformatf("%s[%0d].running", tag, e.idx), {7'd0, running}, {7'd0, e.er});
      end
   endtask

   task automatic apply(vec_t v, int idx, string tag);
      exp_t e;
      clear = v.clr; load = v.ld; load_val = v.ldv; start = v.st; enable = v.en;
      dir = v.dr; limit = v.lim; oneshot = v.os; prescale = v.ps;
      e.eo = v.eo; e.etc = v.etc; e.er = v.er; e.idx = idx;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   task automatic run_table(string tag);
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i, tag);
      vecs.delete();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clear = 0; start = 0; enable = 0; dir = 1; limit = 8'd3;
      oneshot = 0; load = 0; load_val = 0; prescale = 4'd0;
      #12;
      check("reset.out", out, 8'd0);
      check("reset.tc", {7'd0, tc}, 8'd0);
      check("reset.running", {7'd0, running}, 8'd0);
      @(negedge clk);
      reset = 1'b0;

      // Up counter, limit 3, auto-wrap: two tc pulses
      //               clr ld ldv st en dr lim os  eo  tc run
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0, 8'd0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 8'd1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 8'd2, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 8'd3, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 8'd0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 8'd1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 8'd2, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 8'd3, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 8'd0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 8'd0, 0, 1));
      // Down one-shot, limit 4: halts at 0, single tc
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 4, 1, 8'd4, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4, 1, 8'd3, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4, 1, 8'd2, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4, 1, 8'd1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4, 1, 8'd0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4, 1, 8'd0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4, 1, 8'd0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4, 1, 8'd0, 0, 0));
      // Load clamp, then clear beating load
      vecs.push_back(mk(0, 1, 200, 0, 0, 1, 100, 0, 8'd100, 0, 0));
      vecs.push_back(mk(1, 1, 50, 0, 0, 1, 100, 0, 8'd0, 0, 0));
      vecs.push_back(mk(0, 1, 50, 0, 0, 1, 100, 0, 8'd50, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 100, 0, 8'd50, 0, 0));
      // Full range from 254, then limit dropped to 0 below current out
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 255, 0, 8'd0, 0, 1));
      vecs.push_back(mk(0, 1, 254, 0, 0, 1, 255, 0, 8'd254, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 255, 0, 8'd255, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 255, 0, 8'd0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 255, 0, 8'd1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 8'd0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 8'd0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 8'd0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'd0, 0, 1));
      // Restart while running, then direction changes mid-run
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 10, 0, 8'd1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 10, 0, 8'd2, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 10, 0, 8'd0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 10, 0, 8'd10, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 10, 0, 8'd0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 10, 0, 8'd10, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 10, 0, 8'd9, 0, 1));
      // Up one-shot halt then restart from HALT; clear from RUN
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 2, 1, 8'd0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 1, 8'd1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 1, 8'd2, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 1, 8'd2, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2, 1, 8'd0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 1, 1, 2, 1, 8'd0, 0, 0));
      run_table("tbl");

`ifdef PROG_COUNTER_PRESCALE_EN
      // Prescale 2, limit 7: one step every third enabled cycle
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 7, 0, 8'd0, 0, 1));
      for (int i = 1; i <= 9; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 1, 7, 0, 8'(i / 3), 0, 1));
      for (int i = 0; i < vecs.size(); i++) vecs[i].ps = 4'd2;
      run_table("presc");
      prescale = 4'd0;
`endif

      // Asynchronous reset in the middle of a run with out=5
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 10, 0, 8'd0, 0, 1));
      vecs.push_back(mk(0, 1, 5, 0, 0, 1, 10, 0, 8'd5, 0, 1));
      run_table("prerst");
      enable = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset.out", out, 8'd0);
      check("async_reset.tc", {7'd0, tc}, 8'd0);
      check("async_reset.running", {7'd0, running}, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
